// File: rtl/servant_clk_en_ctrl.sv
// Reset synchroniser/stretcher plus per-channel clock-enable FSMs (RUN/DRAIN/SLEEP/WAKE).
// Enables and o_rst are decoded straight from registers; async reset forces all clocks on.
module servant_clk_en_ctrl #(
  parameter int                  CHANNELS     = 2,
  parameter int                  RST_CYCLES   = 16,
  parameter int                  DRAIN_CYCLES = 2,
  parameter int                  WAKE_DELAY   = 4,
  parameter logic [CHANNELS-1:0] ALWAYS_ON    = 2'b01
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_sleep_req,
  input  logic [CHANNELS-1:0] i_wake,
  output logic [CHANNELS-1:0] o_clk_en,
  output logic [CHANNELS-1:0] o_asleep,
  output logic                o_rst
);

  localparam int MAXC    = (DRAIN_CYCLES > WAKE_DELAY) ? DRAIN_CYCLES : WAKE_DELAY;
  localparam int CW      = ($clog2(MAXC + 1) < 1) ? 1 : $clog2(MAXC + 1);
  localparam int DRAIN_LD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int WAKE_LD  = (WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SLEEP,
    ST_WAKE
  } state_e;

  logic [1:0] sync_q;
  logic       rst_sync;
  logic [7:0] rcnt_q, rcnt_d;
  logic       rst_q, rst_d;

  state_e        state_q [CHANNELS];
  state_e        state_d [CHANNELS];
  logic [CW-1:0] cnt_q   [CHANNELS];
  logic [CW-1:0] cnt_d   [CHANNELS];

  // Async assert, sync deassert of the internal reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync = sync_q[1];

  always_comb begin
    rcnt_d = rcnt_q;
    rst_d  = rst_q;
    if (rst_q && rst_sync) begin
      if (rcnt_q == 8'(RST_CYCLES - 1)) begin
        rst_d = 1'b0;
      end else begin
        rcnt_d = rcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rcnt_q <= 8'd0;
      rst_q  <= 1'b1;
    end else begin
      rcnt_q <= rcnt_d;
      rst_q  <= rst_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_RUN;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  // Channels hold in RUN while the downstream reset is still active.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (!rst_q) begin
        case (state_q[c])
          ST_RUN: begin
            if (i_sleep_req[c] && !i_wake[c] && !ALWAYS_ON[c]) begin
              if (DRAIN_CYCLES == 0) begin
                state_d[c] = ST_SLEEP;
              end else begin
                state_d[c] = ST_DRAIN;
                cnt_d[c]   = CW'(DRAIN_LD);
              end
            end
          end
          ST_DRAIN: begin
            if (i_wake[c]) begin
              state_d[c] = ST_RUN;
            end else if (cnt_q[c] == '0) begin
              state_d[c] = ST_SLEEP;
            end else begin
              cnt_d[c] = cnt_q[c] - CW'(1);
            end
          end
          ST_SLEEP: begin
            if (i_wake[c]) begin
              if (WAKE_DELAY == 0) begin
                state_d[c] = ST_RUN;
              end else begin
                state_d[c] = ST_WAKE;
                cnt_d[c]   = CW'(WAKE_LD);
              end
            end
          end
          default: begin
            if (cnt_q[c] == '0) begin
              state_d[c] = ST_RUN;
            end else begin
              cnt_d[c] = cnt_q[c] - CW'(1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      o_clk_en[c] = (state_q[c] != ST_SLEEP) && (state_q[c] != ST_WAKE);
      o_asleep[c] = (state_q[c] == ST_SLEEP);
    end
  end

  assign o_rst = rst_q;

endmodule

// File: tb/tb_servant_clk_en_ctrl.sv
// Scoreboard bench: the driver predicts the outputs after each edge from absolute-time deadlines,
// a separate monitor compares the DUT outputs against the queued predictions.
module tb_servant_clk_en_ctrl;

  localparam int         CH = 2;
  localparam int         RC = 16;
  localparam int         DC = 3;
  localparam int         WD = 4;
  localparam logic [1:0] AO = 2'b01;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [CH-1:0] i_sleep_req = '0;
  logic [CH-1:0] i_wake = '0;
  logic [CH-1:0] o_clk_en;
  logic [CH-1:0] o_asleep;
  logic          o_rst;

  servant_clk_en_ctrl #(
    .CHANNELS    (CH),
    .RST_CYCLES  (RC),
    .DRAIN_CYCLES(DC),
    .WAKE_DELAY  (WD),
    .ALWAYS_ON   (AO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sleep_req(i_sleep_req),
    .i_wake     (i_wake),
    .o_clk_en   (o_clk_en),
    .o_asleep   (o_asleep),
    .o_rst      (o_rst)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          rst;
    logic [CH-1:0] en;
    logic [CH-1:0] asl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  event async_ev;

  // Reference state: edge count, edges since reset release, and per channel a mode
  // (0 awake, 1 draining, 2 asleep, 3 waking) with the absolute edge at which it ends.
  int edge_n = 0;
  int rel = 0;
  int mode[CH];
  int dl[CH];

  function automatic exp_t model_out();
    exp_t e;
    e.rst = (rel < RC + 2);
    for (int c = 0; c < CH; c++) begin
      e.en[c]  = (mode[c] <= 1);
      e.asl[c] = (mode[c] == 2);
    end
    return e;
  endfunction

  task automatic model_reset();
    rel = 0;
    for (int c = 0; c < CH; c++) begin
      mode[c] = 0;
      dl[c]   = 0;
    end
  endtask

  task automatic model_edge();
    bit held;
    edge_n++;
    if (!i_rst_n) begin
      model_reset();
    end else begin
      held = (rel < RC + 2);
      rel++;
      if (!held) begin
        for (int c = 0; c < CH; c++) begin
          case (mode[c])
            0: if (i_sleep_req[c] && !i_wake[c] && !AO[c]) begin
                 mode[c] = (DC == 0) ? 2 : 1;
                 dl[c]   = edge_n + DC;
               end
            1: if (i_wake[c]) mode[c] = 0;
               else if (edge_n == dl[c]) mode[c] = 2;
            2: if (i_wake[c]) begin
                 mode[c] = (WD == 0) ? 0 : 3;
                 dl[c]   = edge_n + WD;
               end
            default: if (edge_n == dl[c]) mode[c] = 0;
          endcase
        end
      end
    end
  endtask

  task automatic step(input logic [CH-1:0] s, input logic [CH-1:0] w, input bit rn = 1'b1);
    @(negedge i_clk);
    i_rst_n     = rn;
    i_sleep_req = s;
    i_wake      = w;
    model_edge();
    q.push_back(model_out());
  endtask

  task automatic async_reset();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    model_reset();
    q.push_back(model_out());
    ->async_ev;
  endtask

  task automatic check_one(input string tag);
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    checks++;
    if (o_rst !== e.rst) begin
      errors++;
      $display("FAIL %s o_rst t=%0t got=%b exp=%b", tag, $time, o_rst, e.rst);
    end
    checks++;
    if (o_clk_en !== e.en) begin
      errors++;
      $display("FAIL %s o_clk_en t=%0t got=%b exp=%b", tag, $time, o_clk_en, e.en);
    end
    checks++;
    if (o_asleep !== e.asl) begin
      errors++;
      $display("FAIL %s o_asleep t=%0t got=%b exp=%b", tag, $time, o_asleep, e.asl);
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    check_one("edge");
  end

  always @(async_ev) begin
    #1;
    check_one("async_rst");
  end

  task automatic rand_steps(input int n);
    logic [CH-1:0] s, w;
    for (int i = 0; i < n; i++) begin
      s = CH'($urandom);
      for (int c = 0; c < CH; c++) w[c] = ($urandom_range(0, 7) == 0);
      step(s, w);
    end
  endtask

  initial begin
    model_reset();
    // Reset held, then release and stretch.
    repeat (5) step(2'b00, 2'b00, 1'b0);
    repeat (22) step(2'b00, 2'b00);
    // Sleep ch1 through drain.
    repeat (6) step(2'b10, 2'b00);
    // Wake pulse, then let the wake delay run out.
    step(2'b00, 2'b10);
    repeat (8) step(2'b00, 2'b00);
    // Abort a drain on its second cycle.
    step(2'b10, 2'b00);
    step(2'b10, 2'b00);
    step(2'b00, 2'b10);
    repeat (5) step(2'b00, 2'b00);
    // Sleep and wake together in RUN: wake wins.
    repeat (3) step(2'b10, 2'b10);
    // Always-on channel ignores a long sleep request.
    repeat (100) step(2'b01, 2'b00);
    // Sleep held across wake: new cycle starts after returning to RUN.
    step(2'b10, 2'b00);
    repeat (4) step(2'b10, 2'b00);
    step(2'b10, 2'b10);
    repeat (12) step(2'b10, 2'b00);
    rand_steps(600);
    // Put ch1 to sleep and pull reset between edges.
    step(2'b00, 2'b10);
    repeat (10) step(2'b00, 2'b00);
    repeat (6) step(2'b10, 2'b00);
    async_reset();
    repeat (3) step(2'b11, 2'b00, 1'b0);
    repeat (20) step(2'b11, 2'b00);
    rand_steps(300);
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain leftover=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
